// File: rtl/rom_note_sequencer.sv
// Single-channel note sequencer: walks a song in a synchronous ROM and drives one
// tone channel with an envelope and an optional vibrato offset on the phase delta.
module rom_note_sequencer #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned ENV_W      = 9,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned START_ADDR = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick_stb,
  input  logic               i_note_stb,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_loop_en,
  input  logic [ADDR_W-1:0]  i_loop_addr,
  input  logic [ADDR_W-1:0]  i_end_addr,
  input  logic [ENV_W-1:0]   i_env_peak,
  input  logic [ENV_W-1:0]   i_env_step,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [15:0]        i_rom_data,
  output logic [NOTE_W-1:0]  o_note,
  input  logic [PHASE_W-1:0] i_note_delta,
  output logic [2:0]         o_vib_sel,
  input  logic [PHASE_W-1:0] i_vib_depth1,
  input  logic [PHASE_W-1:0] i_vib_depth2,
  output logic [PHASE_W-1:0] o_phase_delta,
  output logic [ENV_W-1:0]   o_envelope,
  output logic               o_playing,
  output logic               o_done
);

  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {StIdle, StFetch0, StFetch1, StPlay} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [NOTE_W-1:0]   note_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [1:0]          mode_q;
  logic [2:0]          vib_q, phase_q;
  logic [ENV_W-1:0]    env_q;
  logic [PHASE_W-1:0]  adj_q, adj_d, pd_hold_q, pd_live;
  logic                done_q;
  logic [ENV_W:0]      env_sum;
  logic                in_play, note_end, at_end, latch;

  assign in_play  = (state_q == StPlay);
  assign at_end   = (addr_q == i_end_addr);
  assign note_end = in_play && i_note_stb && (cnt_q == len_q);
  // A stop or restart in F1 abandons the fetched word.
  assign latch    = (state_q == StFetch1) && !i_stop && !i_start;
  assign env_sum  = {1'b0, env_q} + {1'b0, i_env_step};
  assign pd_live  = i_note_delta + adj_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_stop) begin
      state_d = StIdle;
    end else if (i_start) begin
      state_d = StFetch0;
    end else begin
      unique case (state_q)
        StFetch0: state_d = StFetch1;
        StFetch1: state_d = StPlay;
        StPlay:   if (note_end) state_d = (at_end && !i_loop_en) ? StIdle : StFetch0;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_playing     = (state_q != StIdle);
    o_envelope    = (state_q == StIdle || note_q == '0) ? '0 : env_q;
    o_phase_delta = in_play ? pd_live : (state_q == StIdle) ? '0 : pd_hold_q;
  end

  // Vibrato shape over the 8 phases: 0, -d1, -d2, -d1, 0, +d1, +d2, +d1.
  always_comb begin
    adj_d = '0;
    if (vib_q != 3'd0) begin
      case (phase_q)
        3'd1, 3'd3: adj_d = -i_vib_depth1;
        3'd2:       adj_d = -i_vib_depth2;
        3'd5, 3'd7: adj_d = i_vib_depth1;
        3'd6:       adj_d = i_vib_depth2;
        default:    adj_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q    <= '0;
      note_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      vib_q     <= '0;
      phase_q   <= '0;
      env_q     <= '0;
      adj_q     <= '0;
      pd_hold_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= !i_stop && !i_start && note_end && at_end && !i_loop_en;
      if (!i_stop) begin
        if (i_start) addr_q <= StartAddr;
        else if (note_end && at_end && i_loop_en) addr_q <= i_loop_addr;
        else if (note_end && !at_end) addr_q <= addr_q + 1'b1;
      end

      if (in_play)                   pd_hold_q <= pd_live;
      else if (state_q == StIdle)    pd_hold_q <= '0;

      if (latch) begin
        note_q  <= i_rom_data[NOTE_W-1:0];
        len_q   <= i_rom_data[NOTE_W+LEN_W-1:NOTE_W];
        mode_q  <= i_rom_data[12:11];
        vib_q   <= i_rom_data[15:13];
        cnt_q   <= '0;
        phase_q <= '0;
        adj_q   <= '0;
        env_q   <= (i_rom_data[12:11] == 2'd1 || i_rom_data[12:11] == 2'd2) ? i_env_peak : '0;
      end else begin
        adj_q <= adj_d;
        if (in_play && i_note_stb && cnt_q != len_q) cnt_q <= cnt_q + 1'b1;
        if (in_play && i_tick_stb) phase_q <= phase_q + 3'd1;
        if (in_play) begin
          unique case (mode_q)
            2'd0: if (i_tick_stb) env_q <= (env_sum >= {1'b0, i_env_peak}) ? i_env_peak
                                                                            : env_sum[ENV_W-1:0];
            2'd1: if (i_tick_stb) env_q <= (env_q <= i_env_step) ? '0 : env_q - i_env_step;
            2'd2: env_q <= i_env_peak;
            default: env_q <= '0;
          endcase
        end
      end
    end
  end

  assign o_rom_addr = addr_q;
  assign o_note     = note_q;
  assign o_vib_sel  = vib_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_rom_note_sequencer.sv
// Bench for rom_note_sequencer: directed scenarios plus random songs, checked against
// a note-level model of envelope, vibrato and address sequencing.
module tb_rom_note_sequencer;
  localparam int EW = 9;

  logic        i_clk = 1'b0;
  logic        i_rst, i_tick_stb, i_note_stb, i_start, i_stop, i_loop_en;
  logic [4:0]  i_loop_addr, i_end_addr, o_rom_addr;
  logic [8:0]  i_env_peak, i_env_step, o_envelope;
  logic [15:0] i_rom_data;
  logic [5:0]  o_note;
  logic [31:0] i_note_delta, i_vib_depth1, i_vib_depth2, o_phase_delta;
  logic [2:0]  o_vib_sel;
  logic        o_playing, o_done;

  logic [15:0] rom [32];
  logic [31:0] note_tab [64];
  int checks = 0, errors = 0;
  int peak, step, cur, end_a, loop_a;
  bit loop_on;
  logic [31:0] d1, d2;
  int tick_q[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];
  assign i_note_delta = note_tab[o_note];

  rom_note_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_note_stb(i_note_stb),
    .i_start(i_start), .i_stop(i_stop), .i_loop_en(i_loop_en), .i_loop_addr(i_loop_addr),
    .i_end_addr(i_end_addr), .i_env_peak(i_env_peak), .i_env_step(i_env_step),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_note(o_note),
    .i_note_delta(i_note_delta), .o_vib_sel(o_vib_sel), .i_vib_depth1(i_vib_depth1),
    .i_vib_depth2(i_vib_depth2), .o_phase_delta(o_phase_delta), .o_envelope(o_envelope),
    .o_playing(o_playing), .o_done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int note, input int len, input int mode,
                                     input int vib);
    return {3'(vib), 2'(mode), 5'(len), 6'(note)};
  endfunction

  function automatic logic [15:0] rand_word();
    int note;
    note = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
    return mk(note, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 7)));
  endfunction

  // Envelope after k ticks of a note, from the closed-form mode rules.
  function automatic int env_model(input int note, input int mode, input int k);
    if (note == 0) return 0;
    case (mode)
      0: return (k * step >= peak) ? peak : k * step;
      1: return (peak - k * step <= 0) ? 0 : peak - k * step;
      2: return peak;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] pd_model(input int note, input int vsel, input int k);
    logic [31:0] base;
    base = note_tab[note];
    if (vsel == 0) return base;
    case (k % 8)
      1, 3: return base - d1;
      2:    return base - d2;
      5, 7: return base + d1;
      6:    return base + d2;
      default: return base;
    endcase
  endfunction

  task automatic set_env(input int p, input int s, input logic [31:0] a, input logic [31:0] b);
    peak = p; step = s; d1 = a; d2 = b;
    i_env_peak = EW'(p); i_env_step = EW'(s); i_vib_depth1 = a; i_vib_depth2 = b;
  endtask

  task automatic cfg(input int e, input int l, input bit on);
    end_a = e; loop_a = l; loop_on = on;
    i_end_addr = 5'(e); i_loop_addr = 5'(l); i_loop_en = on;
  endtask

  task automatic pulse_note();
    i_note_stb = 1'b1; @(negedge i_clk); i_note_stb = 1'b0;
  endtask

  task automatic chk_silent(input string tag);
    chk({tag, "_playing"}, o_playing, 0);
    chk({tag, "_env"}, o_envelope, 0);
    chk({tag, "_pd"}, o_phase_delta, 0);
  endtask

  // Entered on the negedge where the first fetch cycle for 'cur' is visible.
  task automatic play_note(input int ticks, output bit ended);
    logic [15:0] w;
    int note, len, mode, vsel;
    chk("fetch_addr", o_rom_addr, cur);
    chk("fetch_playing", o_playing, 1);
    w = rom[cur];
    note = int'(w[5:0]); len = int'(w[10:6]); mode = int'(w[12:11]); vsel = int'(w[15:13]);
    @(negedge i_clk); @(negedge i_clk);
    chk("note", o_note, note);
    chk("vib_sel", o_vib_sel, vsel);
    chk("env_k0", o_envelope, env_model(note, mode, 0));
    chk("pd_k0", o_phase_delta, pd_model(note, vsel, 0));
    for (int k = 1; k <= ticks; k++) begin
      i_tick_stb = 1'b1; @(negedge i_clk); i_tick_stb = 1'b0; @(negedge i_clk);
      chk("env_tick", o_envelope, env_model(note, mode, k));
      chk("pd_tick", o_phase_delta, pd_model(note, vsel, k));
    end
    for (int s = 0; s < len; s++) begin
      pulse_note();
      repeat (3) @(negedge i_clk);
      chk("hold_addr", o_rom_addr, cur);
      chk("hold_playing", o_playing, 1);
    end
    pulse_note();
    ended = 1'b0;
    if (cur == end_a) begin
      if (loop_on) cur = loop_a;
      else ended = 1'b1;
    end else begin
      cur = (cur + 1) % 32;
    end
  endtask

  task automatic run_song(input int max_notes, input int tmax);
    bit ended;
    int n, t;
    i_start = 1'b1; @(negedge i_clk); i_start = 1'b0;
    cur = 0; ended = 1'b0; n = 0;
    while (!ended && n < max_notes) begin
      t = (tick_q.size() > 0) ? tick_q.pop_front() : int'($urandom_range(0, tmax));
      play_note(t, ended);
      n++;
    end
    if (ended) begin
      chk("done_pulse", o_done, 1);
      chk_silent("end");
      @(negedge i_clk);
      chk("done_one_cycle", o_done, 0);
    end else begin
      i_stop = 1'b1; @(negedge i_clk); i_stop = 1'b0;
      chk_silent("stop");
    end
  endtask

  initial begin
    i_rst = 1'b1; i_tick_stb = 1'b0; i_note_stb = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    for (int i = 0; i < 64; i++) note_tab[i] = $urandom | 32'd1;
    for (int i = 0; i < 32; i++) rom[i] = rand_word();
    set_env(20, 6, 32'd10, 32'd25);
    cfg(1, 0, 1'b0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk_silent("rst");
    chk("rst_addr", o_rom_addr, 0);
    chk("rst_note", o_note, 0);
    chk("rst_vib", o_vib_sel, 0);
    chk("rst_done", o_done, 0);
    repeat (100) @(negedge i_clk);
    chk_silent("idle100");
    chk("idle100_addr", o_rom_addr, 0);

    // First note: note 5, len 2, constant envelope.
    rom[0] = mk(5, 2, 2, 0);
    run_song(4, 3);

    // Loop region 1..3, then the same song ending without loop.
    cfg(3, 1, 1'b1);
    run_song(7, 2);
    cfg(3, 1, 1'b0);
    run_song(8, 2);

    // Attack, decay and vibrato shapes.
    rom[0] = mk(7, 0, 0, 0);
    rom[1] = mk(9, 0, 1, 0);
    rom[2] = mk(3, 0, 2, 1);
    note_tab[3] = 32'd1000;
    cfg(2, 0, 1'b0);
    tick_q = '{5, 5, 16};
    run_song(3, 0);

    // Rest note with constant envelope stays silent.
    rom[0] = mk(0, 1, 2, 3);
    cfg(0, 0, 1'b0);
    run_song(1, 4);

    // Stop and start together mid-note.
    rom[0] = mk(12, 3, 2, 2);
    i_start = 1'b1; @(negedge i_clk); i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("pre_stop_env", o_envelope, peak);
    i_stop = 1'b1; i_start = 1'b1; @(negedge i_clk); i_stop = 1'b0; i_start = 1'b0;
    chk_silent("stop_start");
    repeat (5) @(negedge i_clk);
    chk_silent("stop_start_late");

    // Restart from PLAY, then reset in the middle of the fetch.
    rom[0] = mk(21, 0, 2, 0); rom[1] = mk(33, 0, 0, 1); rom[2] = mk(44, 1, 2, 0);
    cfg(5, 0, 1'b0);
    begin
      bit ended;
      i_start = 1'b1; @(negedge i_clk); i_start = 1'b0;
      cur = 0;
      play_note(1, ended);
      play_note(1, ended);
      @(negedge i_clk); @(negedge i_clk);
      chk("play_addr2_note", o_note, 44);
      i_start = 1'b1; @(negedge i_clk); i_start = 1'b0;
      chk("restart_addr", o_rom_addr, 0);
      chk("restart_playing", o_playing, 1);
      i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
      chk_silent("rst_fetch");
      chk("rst_fetch_note", o_note, 0);
      chk("rst_fetch_vib", o_vib_sel, 0);
      chk("rst_fetch_done", o_done, 0);
      chk("rst_fetch_addr", o_rom_addr, 0);
    end

    // Address wrap 31 -> 0 inside a loop region.
    for (int i = 0; i < 32; i++) rom[i] = rand_word();
    cfg(1, 30, 1'b1);
    run_song(6, 3);

    // Random songs.
    for (int r = 0; r < 6; r++) begin
      int e;
      for (int i = 0; i < 32; i++) rom[i] = rand_word();
      set_env(int'($urandom_range(0, 511)), int'($urandom_range(0, 80)),
              $urandom_range(0, 5000), $urandom_range(0, 20000));
      e = int'($urandom_range(0, 4));
      cfg(e, int'($urandom_range(0, e)), 1'($urandom_range(0, 1)));
      run_song(8, 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_note_sequencer.md
Name: rom_note_sequencer

Overview:
Parametrised single-channel note sequencer that plays a song from a synchronous-read ROM and drives one tone-generator channel. It adds start/stop control, a programmable loop region and per-note envelope and vibrato selection carried in the ROM word. The channel's note table and vibrato-depth table sit outside the block. Their outputs return through i_note_delta and i_vib_depth1/2.

Parameters:
ADDR_W, 5, ROM address width; song length up to 2^ADDR_W words
LEN_W, 5, note-length field width (note lasts len+1 note strobes)
NOTE_W, 6, note index width; note 0 = rest
ENV_W, 9, envelope output width
PHASE_W, 32, phase-delta width
START_ADDR, 0, first ROM address played after i_start

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_tick_stb  in  1  envelope/vibrato tick (single-cycle pulse)
i_note_stb  in  1  duration tick (single-cycle pulse)
i_start  in  1  pulse: begin playback at START_ADDR
i_stop  in  1  pulse: stop playback and silence the channel
i_loop_en  in  1  loop after end address when 1
i_loop_addr  in  ADDR_W  loop target address
i_end_addr  in  ADDR_W  last song address
i_env_peak  in  ENV_W  envelope peak level
i_env_step  in  ENV_W  envelope increment/decrement per tick
o_rom_addr  out  ADDR_W  ROM address
i_rom_data  in  16  ROM word, valid one cycle after o_rom_addr
o_note  out  NOTE_W  current note index, to the external note table
i_note_delta  in  PHASE_W  base phase delta for o_note (combinational)
o_vib_sel  out  3  vibrato depth select, to the external table
i_vib_depth1  in  PHASE_W  small vibrato offset
i_vib_depth2  in  PHASE_W  large vibrato offset
o_phase_delta  out  PHASE_W  base delta plus vibrato
o_envelope  out  ENV_W  amplitude
o_playing  out  1  high in FETCH and PLAY
o_done  out  1  one-cycle pulse on non-looping song end

Behaviour:
- ROM word fields:
  - note = [NOTE_W-1:0]
  - len = [NOTE_W+LEN_W-1:NOTE_W]
  - env mode = [12:11]
  - vib sel = [15:13]
  - With the defaults these fields are contiguous. Parameters whose fields overlap are unsupported.
- Reset: state IDLE, all registers 0. o_rom_addr=0, o_note=0, o_vib_sel=0, o_envelope=0, o_phase_delta=0, o_playing=0, o_done=0.
- States:
  - IDLE:
    - outputs silent: o_envelope=0, o_phase_delta=0.
    - i_start: o_rom_addr<=START_ADDR, go to FETCH.
  - FETCH (2 cycles: F0 address settle, F1 data valid):
    - At the end of F1, latch note, len and vib sel from i_rom_data.
    - Clear the duration counter, envelope generator and vibrato phase, then go to PLAY.
    - i_note_stb and i_tick_stb are ignored in FETCH. The environment guarantees i_note_stb spacing of at least 4 cycles.
  - PLAY:
    - i_note_stb with count != len: count+1.
    - i_note_stb with count == len: this is the note end.
      - If o_rom_addr == i_end_addr and i_loop_en=1: o_rom_addr<=i_loop_addr, go to FETCH.
      - If o_rom_addr == i_end_addr and i_loop_en=0: go to IDLE and pulse o_done.
      - Otherwise: o_rom_addr+1, wrapping modulo 2^ADDR_W, go to FETCH.
- i_stop in any state: go to IDLE next cycle with outputs silent. i_stop wins over a simultaneous i_start.
- i_start in FETCH or PLAY restarts from START_ADDR (go to FETCH).
- Envelope, in PLAY only, frozen in FETCH, updated on i_tick_stb:
  - mode 0 (attack): start 0, +i_env_step per tick, saturate at i_env_peak.
  - mode 1 (decay): start i_env_peak, -i_env_step per tick, floor at 0 with no underflow.
  - mode 2: constant i_env_peak.
  - mode 3: 0.
  - note==0 (rest) forces o_envelope=0 regardless of mode.
- Vibrato:
  - 3-bit phase, advanced on i_tick_stb in PLAY, wraps 7->0, cleared at note latch.
  - Adjust is registered, one-cycle latency from the phase. Per phase 0..7: 0, -d1, -d2, -d1, 0, +d1, +d2, +d1.
  - o_vib_sel=0 forces adjust=0.
- o_phase_delta = i_note_delta + adjust, modulo 2^PHASE_W, in PLAY. It is 0 in IDLE. In FETCH it holds its last value.

Test Plan:
- Reset, then no start for 100 cycles -> o_playing=0, o_envelope=0, o_phase_delta=0, o_rom_addr=0.
- ROM[0]={note 5, len 2, mode 2}; i_start -> o_note=5 two cycles after FETCH entry. Note advances to addr 1 on the 3rd i_note_stb. o_envelope=i_env_peak throughout.
- i_end_addr=3, i_loop_en=1, i_loop_addr=1 -> address sequence 0,1,2,3,1,2,3,... With i_loop_en=0 instead: after addr 3 ends, o_done pulses for exactly 1 cycle and state returns to IDLE.
- Mode 0, peak 20, step 6 -> o_envelope 0,6,12,18,20,20 on successive ticks. Mode 1 with peak 20, step 6 -> 20,14,8,2,0,0.
- vib sel 1, d1=10, d2=25, i_note_delta=1000 -> o_phase_delta over 8 ticks: 1000,990,975,990,1000,1010,1025,1010, then repeat.
- i_stop and i_start in the same cycle mid-note -> IDLE, output silent. i_rst asserted mid-FETCH -> all outputs 0 on the next cycle. Rest note (note 0) with mode 2 -> o_envelope=0.
